dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Shares the single synchronous-read data-memory port (byte addresses 0x0000–0x2fff, one-cycle read latency) between the CPU M-stage load/store path and a secondary debug/loader requester. CPU has fixed priority, backed by a bounded-starvation guarantee for the secondary side. The block sits between the M-stage memory interface and the memory macro, beside the peripheral bridge. It drives byte write enables, routes read data back to the owning requester, and stalls the CPU when the secondary requester is forced in.

## Interface
- DM_LIMIT, 32'h2fff: highest byte address served by the memory
- WADDR_W, 12: memory word-address width (3072 words)
- STARVE_MAX, 4: consecutive denied cycles after which the secondary requester wins
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  CPU access this cycle (M stage, DM range only)
- c_we  in  1  CPU store
- c_addr  in  32  CPU byte address
- c_be  in  4  CPU byte enables
- c_wd  in  32  CPU store data (already lane-aligned)
- c_stall  out  1  CPU access not performed this cycle; hold M stage
- c_rd  out  32  CPU load data, valid the cycle after a granted read
- d_req  in  1  secondary access request, held until d_gnt
- d_we, d_addr[31:0], d_be[3:0], d_wd[31:0]  in  secondary access fields
- d_gnt  out  1  secondary access accepted this cycle
- d_rvalid  out  1  one-cycle pulse: d_rd/d_err valid
- d_rd  out  32  secondary read data
- d_err  out  1  with d_rvalid: address exceeded DM_LIMIT
- m_en  out  1  memory enable
- m_we  out  4  per-byte write enable
- m_addr  out  WADDR_W  word address (addr[WADDR_W+1:2])
- m_wd  out  32  write data
- m_rd  in  32  read data, one cycle after m_en

## Operation
- Winner selection is combinational each cycle:
  - Secondary wins if d_req && (!c_req || starved).
  - Otherwise CPU wins if c_req.
- starved = (wait_cnt == STARVE_MAX).
- wait_cnt (0..STARVE_MAX, saturating):
  - increments when d_req && !d_gnt;
  - clears when d_gnt or !d_req.
- c_stall = c_req && secondary wins.
- d_gnt = secondary wins.
- Memory drive:
  - m_en = 1 for an in-range winner.
  - m_we = winner_be when winner_we, else 0.
  - m_addr and m_wd come from the winner.
  - No winner: m_en = 0, m_we = 0, m_addr and m_wd hold 0.
- Secondary out of range (d_addr > DM_LIMIT): d_gnt asserts and m_en = 0. Next cycle: d_rvalid = 1, d_err = 1, d_rd = 0. Applies to writes too (write dropped).
- CPU out of range with c_req = 1 is a protocol violation. Required response: no memory access, c_stall = 0.
- Owner register (package enum OWN_NONE/OWN_CPU/OWN_DBG): records the winner of each read, including a secondary error read. Writes record OWN_NONE.
- Read return, cycle after the grant:
  - c_rd = m_rd when owner == OWN_CPU, else 0.
  - For OWN_DBG: d_rvalid = 1 and d_rd = m_rd (or 0 on error).
- Secondary writes also pulse d_rvalid (write acknowledge) with d_rd = 0.

## Timing
- Grant latency:
  - CPU: 0 cycles when not starved.
  - Secondary: at most STARVE_MAX+1 cycles after d_req rises under continuous CPU traffic.
- Read data / d_rvalid: exactly 1 cycle after grant. No back-pressure on the return path.
- Back-to-back grants to either side are legal every cycle. Owner is overwritten each cycle.
- Simultaneous requests with wait_cnt < STARVE_MAX: CPU served, wait_cnt increments.
- Only one d_rvalid pulse per d_gnt.
- Reset (async, any time) clears wait_cnt, owner (OWN_NONE) and d_rvalid/d_err. An in-flight read is discarded: no d_rvalid after reset release.
- Output values during reset: c_rd = 0, d_rd = 0. Combinational outputs follow inputs with no grant bias.

## Structure
- Package dm_arb_pkg:
  - owner enum;
  - DM_LIMIT default;
  - WADDR_W;
  - function word_addr(addr).
- Sub-module dm_arb_starve_cnt: saturating counter with inc/clr inputs and a starved output, parameter STARVE_MAX.
- Top module holds selection logic, the owner register and return muxing.

## Test plan
- CPU-only read: c_req=1, c_addr=0x0010, memory word 4 = 0xDEADBEEF → m_en=1, m_addr=4, c_stall=0; next cycle c_rd=0xDEADBEEF.
- CPU store byte: c_we=1, c_be=4'b0100, c_wd=0x00AB0000, c_addr=0x0022 → m_we=4'b0100, m_addr=8.
- Contention: c_req and d_req held high, STARVE_MAX=4 → CPU granted for 4 cycles. 5th cycle: d_gnt=1, c_stall=1. Next cycle d_rvalid=1 and wait_cnt=0.
- Secondary out of range: d_addr=0x3000 → d_gnt=1, m_en=0; next cycle d_rvalid=1, d_err=1, d_rd=0.
- Reset mid-read: d_gnt on a read, reset low in the same cycle → no d_rvalid. After release: wait_cnt=0 and owner OWN_NONE.
- Interleave: alternate CPU read A / secondary read B on consecutive cycles → each side receives only its own data, one cycle later, with no cross-delivery.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory port arbiter.
//   owner_e     : who owns the read data returning in the next cycle
//   DM_LIMIT_DEF: highest byte address backed by the data memory
//   DM_WADDR_W  : memory word-address width (3072 words)
//   word_addr() : byte address -> word address (caller truncates to width)
// ----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_2fff;
    localparam int          DM_WADDR_W   = 12;

    // Returns the full shifted address so every input bit is consumed; the
    // caller casts down to the memory word-address width.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// dm_arb_starve_cnt
// Saturating count of consecutive cycles the secondary requester was denied.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   i_inc     in  secondary request pending and not granted this cycle
//   i_clr     in  secondary granted or not requesting (wins over i_inc)
//   o_starved out count has reached STARVE_MAX
// ----------------------------------------------------------------------------
module dm_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starved = (r_cnt == CNT_MAX);

endmodule

// File: rtl/dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// dm_port_arbiter
// Shares the single synchronous-read data-memory port between the CPU M-stage
// (fixed priority) and a secondary debug/loader requester, which is forced in
// after STARVE_MAX consecutive denied cycles.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_be/c_wd   CPU access fields (M stage)
//   c_stall                       CPU access displaced by the secondary side
//   c_rd                          CPU load data, cycle after a granted read
//   d_req/d_we/d_addr/d_be/d_wd   secondary access fields, held until d_gnt
//   d_gnt                         secondary access accepted this cycle
//   d_rvalid/d_rd/d_err           secondary response, cycle after d_gnt
//   m_en/m_we/m_addr/m_wd/m_rd    memory macro port (one-cycle read latency)
// ----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT   = dm_arb_pkg::DM_LIMIT_DEF,
    parameter int          WADDR_W    = dm_arb_pkg::DM_WADDR_W,
    parameter int          STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_req,
    input  logic               c_we,
    input  logic [31:0]        c_addr,
    input  logic [3:0]         c_be,
    input  logic [31:0]        c_wd,
    output logic               c_stall,
    output logic [31:0]        c_rd,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [3:0]         d_be,
    input  logic [31:0]        d_wd,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [31:0]        d_rd,
    output logic               d_err,
    output logic               m_en,
    output logic [3:0]         m_we,
    output logic [WADDR_W-1:0] m_addr,
    output logic [31:0]        m_wd,
    input  logic [31:0]        m_rd
);

    logic        w_starved;
    logic        w_d_win;
    logic        w_c_win;
    logic        w_d_inr;
    logic        w_c_inr;
    logic        w_sel_vld;
    logic        w_sel_we;
    logic        w_sel_inr;
    logic [31:0] w_sel_addr;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_wd;

    owner_e      r_owner_p1;
    logic        r_dvld_p1;
    logic        r_err_p1;

    // Winner selection: secondary takes the port when CPU is idle or when the
    // secondary has been denied long enough.
    assign w_d_win = d_req && (!c_req || w_starved);
    assign w_c_win = c_req && !w_d_win;
    assign w_d_inr = (d_addr <= DM_LIMIT);
    assign w_c_inr = (c_addr <= DM_LIMIT);

    dm_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst_n     (reset),
        .i_inc     (d_req && !w_d_win),
        .i_clr     (w_d_win || !d_req),
        .o_starved (w_starved)
    );

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_we   = 1'b0;
        w_sel_inr  = 1'b0;
        w_sel_addr = 32'h0;
        w_sel_be   = 4'h0;
        w_sel_wd   = 32'h0;
        if (w_d_win) begin
            w_sel_vld  = 1'b1;
            w_sel_we   = d_we;
            w_sel_inr  = w_d_inr;
            w_sel_addr = d_addr;
            w_sel_be   = d_be;
            w_sel_wd   = d_wd;
        end else if (w_c_win) begin
            w_sel_vld  = 1'b1;
            w_sel_we   = c_we;
            w_sel_inr  = w_c_inr;
            w_sel_addr = c_addr;
            w_sel_be   = c_be;
            w_sel_wd   = c_wd;
        end
    end

    // Out-of-range winners (secondary error, CPU protocol violation) never
    // touch the macro, so writes to them are dropped here.
    assign m_en    = w_sel_vld && w_sel_inr;
    assign m_we    = (m_en && w_sel_we) ? w_sel_be : 4'h0;
    assign m_addr  = WADDR_W'(word_addr(w_sel_addr));
    assign m_wd    = w_sel_wd;
    assign c_stall = c_req && w_d_win;
    assign d_gnt   = w_d_win;

    // ---- grant stage -> return stage (memory read latency) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner_p1 <= OWN_NONE;
            r_dvld_p1  <= 1'b0;
            r_err_p1   <= 1'b0;
        end else begin
            r_dvld_p1 <= w_d_win;
            r_err_p1  <= w_d_win && !w_d_inr;
            if (w_d_win && !d_we) begin
                r_owner_p1 <= OWN_DBG;
            end else if (w_c_win && !c_we && w_c_inr) begin
                r_owner_p1 <= OWN_CPU;
            end else begin
                r_owner_p1 <= OWN_NONE;
            end
        end
    end

    // Return muxing: each side only ever sees data it owns; writes and error
    // responses return zero.
    assign c_rd     = (r_owner_p1 == OWN_CPU) ? m_rd : 32'h0;
    assign d_rvalid = r_dvld_p1;
    assign d_err    = r_dvld_p1 && r_err_p1;
    assign d_rd     = ((r_owner_p1 == OWN_DBG) && !r_err_p1) ? m_rd : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    logic        c_stall;
    logic [31:0] c_rd;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wd;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rd;
    logic        m_en;
    logic [3:0]  m_we;
    logic [11:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_rd;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [0:3071];

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_be     (c_be),
        .c_wd     (c_wd),
        .c_stall  (c_stall),
        .c_rd     (c_rd),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_be     (d_be),
        .d_wd     (d_wd),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rd     (d_rd),
        .d_err    (d_err),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wd     (m_wd),
        .m_rd     (m_rd)
    );

    // Synchronous-read memory macro model with byte writes; known words are
    // loaded while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            mem[4] <= 32'hDEAD_BEEF;
            mem[5] <= 32'h5555_5555;
            mem[6] <= 32'h0000_0000;
            mem[8] <= 32'h1122_3344;
            mem[12'hbff] <= 32'h0BFF_0BFF;
        end else if (m_en) begin
            if (m_we == 4'h0) begin
                m_rd <= mem[m_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wd[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = 0; c_be = 0; c_wd = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wd = 0;
    endtask

    initial begin
        m_rd  = 32'h0;
        reset = 1'b0;
        idle();
        // Reset state; combinational path still follows inputs
        c_req = 1; c_addr = 32'h10;
        #2;
        chk("rst_m_en", m_en, 1);
        chk("rst_m_addr", m_addr, 12'h004);
        chk("rst_c_rd", c_rd, 0);
        chk("rst_d_rd", d_rd, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_err", d_err, 0);
        idle();
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // CPU-only read
        c_req = 1; c_addr = 32'h10;
        #1;
        chk("cpu_rd_m_en", m_en, 1);
        chk("cpu_rd_m_addr", m_addr, 12'h004);
        chk("cpu_rd_stall", c_stall, 0);
        chk("cpu_rd_m_we", m_we, 4'h0);
        tick();
        idle();
        chk("cpu_rd_data", c_rd, 32'hDEAD_BEEF);
        chk("cpu_rd_no_dvld", d_rvalid, 0);

        // CPU byte store, then read back
        c_req = 1; c_we = 1; c_be = 4'b0100; c_wd = 32'h00AB_0000; c_addr = 32'h22;
        #1;
        chk("cpu_st_m_we", m_we, 4'b0100);
        chk("cpu_st_m_addr", m_addr, 12'h008);
        chk("cpu_st_m_wd", m_wd, 32'h00AB_0000);
        tick();
        chk("cpu_st_no_crd", c_rd, 0);
        c_we = 0; c_be = 0; c_wd = 0; c_addr = 32'h20;
        tick();
        idle();
        chk("cpu_st_readback", c_rd, 32'h11AB_3344);

        // Contention: CPU four cycles, secondary forced in on the fifth;
        // repeated immediately to show the wait count restarted from zero.
        c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h14;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                chk("cont_dgnt_low", d_gnt, 0);
                chk("cont_stall_low", c_stall, 0);
                tick();
                chk("cont_crd", c_rd, 32'hDEAD_BEEF);
            end
            #1;
            chk("cont_dgnt", d_gnt, 1);
            chk("cont_stall", c_stall, 1);
            chk("cont_m_addr", m_addr, 12'h005);
            tick();
            chk("cont_dvld", d_rvalid, 1);
            chk("cont_drd", d_rd, 32'h5555_5555);
            chk("cont_no_crd", c_rd, 0);
        end
        idle();
        tick();
        chk("cont_single_pulse", d_rvalid, 0);

        // Secondary at the last in-range word
        d_req = 1; d_addr = 32'h2ffc;
        #1;
        chk("bnd_dgnt", d_gnt, 1);
        chk("bnd_m_en", m_en, 1);
        chk("bnd_m_addr", m_addr, 12'hbff);
        tick();
        chk("bnd_dvld", d_rvalid, 1);
        chk("bnd_derr", d_err, 0);
        chk("bnd_drd", d_rd, 32'h0BFF_0BFF);

        // Secondary out of range
        d_addr = 32'h3000;
        #1;
        chk("oor_dgnt", d_gnt, 1);
        chk("oor_m_en", m_en, 0);
        tick();
        idle();
        chk("oor_dvld", d_rvalid, 1);
        chk("oor_derr", d_err, 1);
        chk("oor_drd", d_rd, 0);
        tick();
        chk("oor_single_pulse", d_rvalid, 0);

        // Secondary write acknowledge, then CPU reads it back
        d_req = 1; d_we = 1; d_be = 4'hF; d_wd = 32'hCAFE_F00D; d_addr = 32'h18;
        #1;
        chk("dwr_dgnt", d_gnt, 1);
        chk("dwr_m_we", m_we, 4'hF);
        chk("dwr_m_addr", m_addr, 12'h006);
        chk("dwr_m_wd", m_wd, 32'hCAFE_F00D);
        tick();
        idle();
        chk("dwr_dvld", d_rvalid, 1);
        chk("dwr_drd", d_rd, 0);
        chk("dwr_derr", d_err, 0);
        c_req = 1; c_addr = 32'h18;
        tick();
        idle();
        chk("dwr_readback", c_rd, 32'hCAFE_F00D);

        // CPU out of range: no access, no stall, no data
        c_req = 1; c_addr = 32'h3000;
        #1;
        chk("coor_m_en", m_en, 0);
        chk("coor_stall", c_stall, 0);
        tick();
        idle();
        chk("coor_crd", c_rd, 0);

        // Interleave CPU read A / secondary read B
        for (int k = 0; k < 2; k++) begin
            c_req = 1; c_addr = 32'h10;
            #1;
            chk("il_a_stall", c_stall, 0);
            tick();
            c_req = 0; d_req = 1; d_addr = 32'h14;
            chk("il_a_crd", c_rd, 32'hDEAD_BEEF);
            chk("il_a_no_dvld", d_rvalid, 0);
            chk("il_a_no_drd", d_rd, 0);
            #1;
            chk("il_b_dgnt", d_gnt, 1);
            tick();
            idle();
            chk("il_b_dvld", d_rvalid, 1);
            chk("il_b_drd", d_rd, 32'h5555_5555);
            chk("il_b_no_crd", c_rd, 0);
        end
        tick();

        // Reset while a secondary read is in flight
        d_req = 1; d_addr = 32'h14;
        #1;
        chk("rmid_dgnt", d_gnt, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rmid_async_dvld", d_rvalid, 0);
        tick();
        chk("rmid_dvld", d_rvalid, 0);
        chk("rmid_drd", d_rd, 0);
        reset = 1'b1;
        idle();
        tick();
        chk("rmid_post_dvld", d_rvalid, 0);
        chk("rmid_post_crd", c_rd, 0);
        c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h14;
        #1;
        chk("rmid_not_starved", d_gnt, 0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
